// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS MEM stage.
package mem_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W_DEF = 32;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] BYTE_OFS_MASK = 2'b11;

  typedef enum logic {
    MEM_ST_IDLE   = 1'b0,
    MEM_ST_ACCESS = 1'b1
  } mem_state_e;

  // Context of an in-flight memory access, needed at retire time.
  typedef struct packed {
    logic                  is_load;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
  } acc_ctx_t;

  function automatic logic is_word_aligned(input logic [1:0] byte_ofs);
    return (byte_ofs & BYTE_OFS_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_timer.sv
// Saturating access timer with clear/enable and a terminal-count flag.
module mem_access_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT_VAL = '1;

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles; clear wins, and the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != SAT_VAL)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign tc_c = (count_q == TC_VAL);

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: forwards ALU ops, runs load/store handshakes with timeout.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_write_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_write_reg,
  output logic                  stall_out,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  misalign_err,
  output logic                  bus_err
);

  mem_state_e state_q, state_d;
  acc_ctx_t   ctx_q, ctx_d;

  logic                  req_d, we_d;
  logic [DATA_W-1:0]     addr_d, wdata_d;
  logic                  wb_valid_d, wb_reg_write_d;
  logic [REG_ADDR_W-1:0] wb_write_reg_d;
  logic [DATA_W-1:0]     wb_data_d;
  logic                  misalign_d, bus_err_d;

  logic tmr_clr, tmr_en, tmr_tc;
  logic is_mem_op, is_bad_op;

  assign is_mem_op = ex_mem_read | ex_mem_write;
  assign is_bad_op = is_mem_op &&
                     (!is_word_aligned(ex_alu_result[1:0]) || (ex_mem_read && ex_mem_write));

  // Stall is a pure decode of the state flop.
  assign stall_out = (state_q == MEM_ST_ACCESS);

  mem_access_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc_c  (tmr_tc)
  );

  // Next-state and next-output logic; error flags and wb_valid default to idle pulses.
  always_comb begin
    state_d        = state_q;
    ctx_d          = ctx_q;
    req_d          = dmem_req;
    we_d           = dmem_we;
    addr_d         = dmem_addr;
    wdata_d        = dmem_wdata;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write;
    wb_write_reg_d = wb_write_reg;
    wb_data_d      = wb_data;
    misalign_d     = 1'b0;
    bus_err_d      = 1'b0;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;

    case (state_q)
      MEM_ST_IDLE: begin
        if (ex_valid) begin
          if (!is_mem_op) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = ex_alu_result;
            wb_reg_write_d = ex_reg_write;
            wb_write_reg_d = ex_write_reg;
          end else if (is_bad_op) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            misalign_d     = 1'b1;
          end else begin
            req_d           = 1'b1;
            we_d            = ex_mem_write;
            addr_d          = {ex_alu_result[DATA_W-1:2], 2'b00};
            wdata_d         = ex_write_data;
            ctx_d.is_load   = ex_mem_read;
            ctx_d.reg_write = ex_reg_write;
            ctx_d.write_reg = ex_write_reg;
            tmr_clr         = 1'b1;
            state_d         = MEM_ST_ACCESS;
          end
        end
      end

      MEM_ST_ACCESS: begin
        if (dmem_ack) begin
          req_d          = 1'b0;
          wb_valid_d     = 1'b1;
          wb_write_reg_d = ctx_q.write_reg;
          state_d        = MEM_ST_IDLE;
          if (ctx_q.is_load) begin
            wb_data_d      = dmem_rdata;
            wb_reg_write_d = ctx_q.reg_write;
          end else begin
            wb_data_d      = dmem_addr;
            wb_reg_write_d = 1'b0;
          end
        end else if (tmr_tc) begin
          req_d          = 1'b0;
          bus_err_d      = 1'b1;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = 1'b0;
          state_d        = MEM_ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: state_d = MEM_ST_IDLE;
    endcase
  end

  // State, memory-interface and MEM/WB registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MEM_ST_IDLE;
      ctx_q        <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_write_reg <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctx_q        <= ctx_d;
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_wdata   <= wdata_d;
      wb_valid     <= wb_valid_d;
      wb_reg_write <= wb_reg_write_d;
      wb_write_reg <= wb_write_reg_d;
      wb_data      <= wb_data_d;
      misalign_err <= misalign_d;
      bus_err      <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;

  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;
  localparam int unsigned CW  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [DW-1:0] ex_alu_result, ex_write_data;
  logic [4:0]    ex_write_reg;
  logic          stall_out, dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          wb_valid, wb_reg_write, misalign_err, bus_err;
  logic [4:0]    wb_write_reg;
  logic [DW-1:0] wb_data;

  mem_stage #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_data(wb_data), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // One EX-stage op plus how the memory will answer it (dly > TMO: never acks).
  typedef struct {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd;
    logic        wr;
    logic        rw;
    logic [4:0]  rg;
    int          dly;
  } op_t;

  int n_chk = 0;
  int n_bad = 0;

  // Last cleanly retired wb_data, used to check that wb_data holds while idle.
  bit          hist_ok = 1'b0;
  logic [31:0] hist_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [31:0] alu, input logic [31:0] wdata,
                             input logic rd, input logic wr, input logic rw,
                             input logic [4:0] rg, input int dly, input logic [31:0] rdata);
    op_t o;
    o.alu = alu; o.wdata = wdata; o.rd = rd; o.wr = wr; o.rw = rw;
    o.rg = rg; o.dly = dly; o.rdata = rdata;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  k;
    k       = int'($urandom_range(0, 99));
    o.alu   = $urandom & 32'hFFFF_FFFC;
    o.wdata = $urandom;
    o.rdata = $urandom;
    o.rg    = 5'($urandom);
    o.rw    = 1'($urandom);
    o.rd    = 1'b0;
    o.wr    = 1'b0;
    if (k < 40) begin
      o.alu = $urandom;
    end else if (k < 65) begin
      o.rd = 1'b1;
    end else if (k < 85) begin
      o.wr = 1'b1;
    end else if (k < 93) begin
      o.rd  = 1'($urandom);
      o.wr  = ~o.rd;
      o.alu = o.alu | 32'($urandom_range(1, 3));
    end else begin
      o.rd = 1'b1;
      o.wr = 1'b1;
    end
    o.dly = ($urandom_range(0, 9) == 0) ? int'(TMO) + 1 : int'($urandom_range(1, TMO));
    return o;
  endfunction

  function automatic bit op_is_mem(input op_t o);
    return o.rd | o.wr;
  endfunction

  function automatic bit op_is_bad(input op_t o);
    logic [1:0] ofs;
    ofs = o.alu[1:0];
    return op_is_mem(o) && ((ofs != 2'b00) || (o.rd && o.wr));
  endfunction

  task automatic drive(input op_t o, input logic v);
    ex_valid      = v;
    ex_alu_result = o.alu;
    ex_write_data = o.wdata;
    ex_mem_read   = o.rd;
    ex_mem_write  = o.wr;
    ex_reg_write  = o.rw;
    ex_write_reg  = o.rg;
  endtask

  task automatic drive_idle();
    ex_valid      = 1'b0;
    ex_alu_result = $urandom;
    ex_write_data = $urandom;
    ex_mem_read   = 1'($urandom);
    ex_mem_write  = 1'($urandom);
    ex_reg_write  = 1'($urandom);
    ex_write_reg  = 5'($urandom);
  endtask

  // Expected MEM/WB contents on the retire cycle of op o.
  task automatic check_retire(input op_t o, input bit timed_out);
    bit bad;
    bad = op_is_bad(o);
    chk("ret_wb_valid", 32'(wb_valid), 32'd1);
    chk("ret_stall", 32'(stall_out), 32'd0);
    chk("ret_req", 32'(dmem_req), 32'd0);
    chk("ret_misalign", 32'(misalign_err), 32'(bad));
    chk("ret_bus_err", 32'(bus_err), 32'(timed_out));
    if (!op_is_mem(o)) begin
      chk("alu_data", wb_data, o.alu);
      chk("alu_regwr", 32'(wb_reg_write), 32'(o.rw));
      chk("alu_reg", 32'(wb_write_reg), 32'(o.rg));
      hist_ok = 1'b1; hist_data = o.alu;
    end else if (bad || timed_out) begin
      chk("err_regwr", 32'(wb_reg_write), 32'd0);
      hist_ok = 1'b0;
    end else if (o.rd) begin
      chk("ld_data", wb_data, o.rdata);
      chk("ld_regwr", 32'(wb_reg_write), 32'(o.rw));
      chk("ld_reg", 32'(wb_write_reg), 32'(o.rg));
      hist_ok = 1'b1; hist_data = o.rdata;
    end else begin
      chk("st_data", wb_data, o.alu);
      chk("st_regwr", 32'(wb_reg_write), 32'd0);
      hist_ok = 1'b1; hist_data = o.alu;
    end
  endtask

  // Present op o from a negedge; while stalled, optionally hold the next op upstream.
  task automatic run_op(input op_t o, input op_t nxt, input bit hold);
    int n;
    bit done;
    drive(o, 1'b1);
    @(posedge clk);
    if (!op_is_mem(o) || op_is_bad(o)) begin
      @(negedge clk);
      chk("nm_req", 32'(dmem_req), 32'd0);
      check_retire(o, 1'b0);
      return;
    end
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      chk("acc_req", 32'(dmem_req), 32'd1);
      chk("acc_stall", 32'(stall_out), 32'd1);
      chk("acc_we", 32'(dmem_we), 32'(o.wr));
      chk("acc_addr", dmem_addr, o.alu);
      chk("acc_wdata", dmem_wdata, o.wdata);
      chk("acc_wb_valid", 32'(wb_valid), 32'd0);
      chk("acc_errs", 32'({misalign_err, bus_err}), 32'd0);
      if (hold) drive(nxt, 1'b1);
      else      drive_idle();
      dmem_ack   = (n == o.dly);
      dmem_rdata = (n == o.dly) ? o.rdata : $urandom;
      @(posedge clk);
      done = (n == o.dly) || (n == int'(TMO));
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    check_retire(o, o.dly > int'(TMO));
  endtask

  task automatic idle_cycle();
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    chk("idle_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_errs", 32'({misalign_err, bus_err}), 32'd0);
    chk("idle_stall_req", 32'({stall_out, dmem_req}), 32'd0);
    if (hist_ok) chk("idle_hold", wb_data, hist_data);
  endtask

  op_t none_op;
  op_t ops[$];

  initial begin
    none_op    = mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1, 32'h0);
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    drive_idle();

    // Reset values.
    #12;
    chk("rst_outs", 32'({stall_out, dmem_req, dmem_we, wb_valid, wb_reg_write,
                         misalign_err, bus_err}), 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // Directed cases.
    run_op(mk(32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8, 1, 32'h0), none_op, 1'b0);
    idle_cycle();
    run_op(mk(32'h0000_0100, 32'h5555_0000, 1'b1, 1'b0, 1'b1, 5'd9, 3, 32'hDEAD_BEEF),
           none_op, 1'b0);
    idle_cycle();
    run_op(mk(32'h0000_0204, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 5'd3, 1, 32'h0), none_op, 1'b0);
    idle_cycle();
    run_op(mk(32'h0000_0102, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4, 1, 32'h0), none_op, 1'b0);
    idle_cycle();
    run_op(mk(32'h0000_0300, 32'h0, 1'b1, 1'b1, 1'b1, 5'd5, 1, 32'h0), none_op, 1'b0);
    idle_cycle();
    // Timeout with the next op held upstream, then accepted on the first idle edge.
    run_op(mk(32'h0000_0400, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6, int'(TMO) + 1, 32'h0),
           mk(32'h0000_0AB0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 1, 32'h0), 1'b1);
    run_op(mk(32'h0000_0AB0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 1, 32'h0), none_op, 1'b0);
    // Ack on the last allowed cycle wins over timeout.
    run_op(mk(32'h0000_0500, 32'h0, 1'b1, 1'b0, 1'b1, 5'd10, int'(TMO), 32'hCAFE_F00D),
           none_op, 1'b0);
    // Back-to-back ALU ops at full rate.
    run_op(mk(32'h1111_1111, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 1, 32'h0), none_op, 1'b0);
    run_op(mk(32'h2222_2222, 32'h0, 1'b0, 1'b0, 1'b0, 5'd2, 1, 32'h0), none_op, 1'b0);
    run_op(mk(32'h3333_3333, 32'h0, 1'b0, 1'b0, 1'b1, 5'd31, 1, 32'h0), none_op, 1'b0);
    idle_cycle();

    // Reset in the middle of an access.
    drive(mk(32'h0000_0600, 32'h0, 1'b1, 1'b0, 1'b1, 5'd12, int'(TMO) + 1, 32'h0), 1'b1);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      drive_idle();
    end
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_stall", 32'({dmem_req, stall_out}), 32'd0);
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_wb", 32'({wb_valid, bus_err, dmem_req}), 32'd0);
    rst_n = 1'b1;
    hist_ok = 1'b1;
    hist_data = 32'h0;
    idle_cycle();
    run_op(mk(32'h0000_0777, 32'h0, 1'b0, 1'b0, 1'b1, 5'd13, 1, 32'h0), none_op, 1'b0);
    run_op(mk(32'h0000_0800, 32'h0, 1'b1, 1'b0, 1'b1, 5'd14, 2, 32'hA5A5_5A5A),
           none_op, 1'b0);

    // Random op stream with random gaps and held ops during stalls.
    for (int i = 0; i < 201; i++) ops.push_back(rand_op());
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(ops[i], ops[i+1], gap == 0);
      repeat (gap) idle_cycle();
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
